// File: rtl/rx_iq_packer_pkg.sv
// Shared constants for the RX sample packer and the USB transmit engine.
// Block geometry and ADC full-scale codes.
package rx_iq_packer_pkg;
   localparam int WORDS_PER_BLOCK  = 82;
   localparam int RX_PAYLOAD_BYTES = 492;
   localparam int ADC_BITS         = 16;
   localparam int CLIP_HOLD        = 12_288_000;

   localparam logic [ADC_BITS-1:0] ADC_FS_POS = {1'b0, {(ADC_BITS-1){1'b1}}};
   localparam logic [ADC_BITS-1:0] ADC_FS_NEG = {1'b1, {(ADC_BITS-1){1'b0}}};
endpackage

// File: rtl/rx_iq_packer_clip_stretch.sv
// ADC overload detector with a retriggerable hold counter.
// clip rises one clock after a full-scale code and stays up CLIP_HOLD clocks.
module clip_stretch #(
   parameter int ADC_BITS  = 16,
   parameter int CLIP_HOLD = 12_288_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADC_BITS-1:0] adc_data,
   output logic                clip
);
   localparam int CW = (CLIP_HOLD > 2) ? $clog2(CLIP_HOLD) : 1;
   localparam logic [ADC_BITS-1:0] FS_POS = {1'b0, {(ADC_BITS-1){1'b1}}};
   localparam logic [ADC_BITS-1:0] FS_NEG = {1'b1, {(ADC_BITS-1){1'b0}}};
   localparam logic [CW-1:0] HOLD_LAST = CW'(CLIP_HOLD - 1);

   logic [CW-1:0] clip_cnt;
   logic          ovl;

   assign ovl = (adc_data == FS_POS) || (adc_data == FS_NEG);

   // Load the hold count on overload, otherwise run it down to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clip_cnt <= '0;
         clip     <= 1'b0;
      end else if (ovl) begin
         clip_cnt <= HOLD_LAST;
         clip     <= 1'b1;
      end else if (clip_cnt != '0) begin
         clip_cnt <= clip_cnt - 1'b1;
         clip     <= 1'b1;
      end else begin
         clip     <= 1'b0;
      end
   end
endmodule

// File: rtl/rx_iq_packer.sv
// Packs DDC I/Q samples into 48-bit words of a ping-pong sample RAM.
// Announces each completed half on adc_mem_block; also drives the clip flag.
module rx_iq_packer
   import rx_iq_packer_pkg::*;
#(
   parameter int WORDS     = WORDS_PER_BLOCK,
   parameter int ABITS     = ADC_BITS,
   parameter int HOLD      = CLIP_HOLD
) (
   input  logic             adc_clock,
   input  logic             reset,
   input  logic             rx_on,
   input  logic             iq_strobe,
   input  logic [23:0]      i_data,
   input  logic [23:0]      q_data,
   input  logic [ABITS-1:0] adc_data,
   output logic             mem_we,
   output logic [7:0]       mem_waddr,
   output logic [47:0]      mem_wdata,
   output logic             adc_mem_block,
   output logic             clip
);
   localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);

   logic       wr_half;
   logic [6:0] word_cnt;

   // Registered RAM write and ping-pong half control; first half filled is 1.
   always_ff @(posedge adc_clock) begin
      if (!reset) begin
         mem_we        <= 1'b0;
         mem_waddr     <= '0;
         mem_wdata     <= '0;
         adc_mem_block <= 1'b0;
         wr_half       <= 1'b1;
         word_cnt      <= '0;
      end else begin
         mem_we <= 1'b0;
         if (!rx_on) begin
            word_cnt <= '0;
         end else if (iq_strobe) begin
            mem_we    <= 1'b1;
            mem_waddr <= {wr_half, word_cnt};
            mem_wdata <= {i_data, q_data};
            if (word_cnt == LAST_WORD) begin
               word_cnt      <= '0;
               adc_mem_block <= wr_half;
               wr_half       <= ~wr_half;
            end else begin
               word_cnt <= word_cnt + 7'd1;
            end
         end
      end
   end

   clip_stretch #(
      .ADC_BITS  (ABITS),
      .CLIP_HOLD (HOLD)
   ) u_clip (
      .clk      (adc_clock),
      .reset    (reset),
      .adc_data (adc_data),
      .clip     (clip)
   );
endmodule

// File: tb/tb_rx_iq_packer.sv
// Self-checking bench for rx_iq_packer with a short clip hold.
// Block-level model plus directed literal checks.
module tb_rx_iq_packer;
   localparam int HOLD = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_on = 1'b0;
   logic        iq_strobe = 1'b0;
   logic [23:0] i_data = '0;
   logic [23:0] q_data = '0;
   logic [15:0] adc_data = '0;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [47:0] mem_wdata;
   logic        adc_mem_block;
   logic        clip;

   int n_checks = 0;
   int n_fail = 0;

   rx_iq_packer #(.HOLD(HOLD)) dut (
      .adc_clock     (clk),
      .reset         (reset),
      .rx_on         (rx_on),
      .iq_strobe     (iq_strobe),
      .i_data        (i_data),
      .q_data        (q_data),
      .adc_data      (adc_data),
      .mem_we        (mem_we),
      .mem_waddr     (mem_waddr),
      .mem_wdata     (mem_wdata),
      .adc_mem_block (adc_mem_block),
      .clip          (clip)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: counts accepted samples and completed blocks, ages the last overload.
   int          blocks = 0;
   int          nword = 0;
   int          age = HOLD;
   bit          m_valid = 0;
   logic        m_we = 0;
   logic [7:0]  m_addr = 0;
   logic [47:0] m_data = 0;
   logic        m_blk = 0;
   logic        m_clip = 0;

   always @(posedge clk) begin
      m_valid = 1;
      if (!reset) begin
         blocks = 0; nword = 0; age = HOLD;
         m_we = 0; m_addr = 0; m_data = 0;
      end else begin
         m_we = 0;
         if (!rx_on) nword = 0;
         else if (iq_strobe) begin
            m_we   = 1;
            m_addr = (blocks % 2 == 0 ? 8'd128 : 8'd0) + 8'(nword);
            m_data = {i_data, q_data};
            nword++;
            if (nword == 82) begin
               nword = 0;
               blocks++;
            end
         end
         if (adc_data == 16'h7FFF || adc_data == 16'h8000) age = 0;
         else if (age < HOLD) age++;
      end
      m_blk  = (blocks % 2) == 1;
      m_clip = age < HOLD;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         check("we", 64'(mem_we), 64'(m_we));
         check("waddr", 64'(mem_waddr), 64'(m_addr));
         check("wdata", 64'(mem_wdata), 64'(m_data));
         check("blk", 64'(adc_mem_block), 64'(m_blk));
         check("clip", 64'(clip), 64'(m_clip));
      end
   end

   // Write log and toggle counter for directed checks.
   logic [7:0]  wq_addr[$];
   logic [47:0] wq_data[$];
   logic        wq_blk[$];
   int          toggles = 0;
   logic        prev_blk = 0;

   always @(negedge clk) begin
      if (mem_we) begin
         wq_addr.push_back(mem_waddr);
         wq_data.push_back(mem_wdata);
         wq_blk.push_back(adc_mem_block);
      end
      if (adc_mem_block != prev_blk) toggles++;
      prev_blk = adc_mem_block;
   end

   task automatic strobe(input logic [23:0] i, input logic [23:0] q, input int gap);
      @(negedge clk);
      iq_strobe = 1; i_data = i; q_data = q;
      @(negedge clk);
      iq_strobe = 0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      settle();
   endtask

   int base, tog0, hi;

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_we", 64'(mem_we), 64'd0);
      check("rst_addr", 64'(mem_waddr), 64'd0);
      check("rst_data", 64'(mem_wdata), 64'd0);
      check("rst_blk", 64'(adc_mem_block), 64'd0);
      check("rst_clip", 64'(clip), 64'd0);
      reset = 1; rx_on = 1;
      settle();

      // First block, 4 clocks apart.
      base = wq_addr.size(); tog0 = toggles;
      for (int k = 0; k < 82; k++) strobe(24'(k), 24'(k + 1000), 4);
      settle();
      check("b1_n", 64'(wq_addr.size() - base), 64'd82);
      check("b1_first", 64'(wq_addr[base]), 64'h80);
      check("b1_last", 64'(wq_addr[base + 81]), 64'hD1);
      check("b1_blk80", 64'(wq_blk[base + 80]), 64'd0);
      check("b1_blk81", 64'(wq_blk[base + 81]), 64'd1);
      check("b1_data", 64'(wq_data[base + 5]), 64'h000005_0003ED);

      // Second block.
      base = wq_addr.size();
      for (int k = 0; k < 82; k++) strobe(24'(k), 24'(k), 4);
      settle();
      check("b2_first", 64'(wq_addr[base]), 64'h00);
      check("b2_last", 64'(wq_addr[base + 81]), 64'h51);
      check("b2_blk", 64'(adc_mem_block), 64'd0);
      check("b2_tog", 64'(toggles - tog0), 64'd2);

      // Back-to-back strobes across a wrap.
      base = wq_addr.size();
      for (int k = 0; k < 100; k++) strobe(24'h123456, 24'hABCDEF, 1);
      settle();
      check("bb_n", 64'(wq_addr.size() - base), 64'd100);
      check("bb_data", 64'(wq_data[base + 90]), 64'h123456ABCDEF);
      check("bb_a81", 64'(wq_addr[base + 81]), 64'hD1);
      check("bb_a82", 64'(wq_addr[base + 82]), 64'h00);

      // rx_on drop mid-block discards the partial half.
      do_reset();
      tog0 = toggles;
      for (int k = 0; k < 40; k++) strobe(24'(k), 24'(k), 2);
      @(negedge clk); rx_on = 0;
      for (int k = 0; k < 10; k++) strobe(24'hFFFFFF, 24'hFFFFFF, 1);
      rx_on = 1;
      settle();
      check("off_blk", 64'(adc_mem_block), 64'd0);
      base = wq_addr.size();
      for (int k = 0; k < 82; k++) strobe(24'(k), 24'(k), 2);
      settle();
      check("rs_n", 64'(wq_addr.size() - base), 64'd82);
      check("rs_first", 64'(wq_addr[base]), 64'h80);
      check("rs_blk80", 64'(wq_blk[base + 80]), 64'd0);
      check("rs_blk81", 64'(wq_blk[base + 81]), 64'd1);
      check("rs_tog", 64'(toggles - tog0), 64'd1);

      // Clip: single overload, retrigger, near-full-scale.
      hi = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         hi += int'(clip);
         adc_data = (k == 0) ? 16'h7FFF : 16'h0000;
      end
      check("clip_one", 64'(hi), 64'd16);
      hi = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         hi += int'(clip);
         adc_data = (k == 0) ? 16'h7FFF : (k == 6) ? 16'h8000 : 16'h0000;
      end
      check("clip_retrig", 64'(hi), 64'd22);
      hi = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         hi += int'(clip);
         adc_data = (k < 5) ? 16'h7FFE : 16'h0000;
      end
      check("clip_7ffe", 64'(hi), 64'd0);

      // Reset mid-block.
      for (int k = 0; k < 50; k++) strobe(24'(k), 24'(k), 1);
      @(negedge clk); reset = 0;
      @(negedge clk);
      check("mr_we", 64'(mem_we), 64'd0);
      check("mr_addr", 64'(mem_waddr), 64'd0);
      check("mr_data", 64'(mem_wdata), 64'd0);
      check("mr_blk", 64'(adc_mem_block), 64'd0);
      reset = 1;
      settle();
      base = wq_addr.size();
      for (int k = 0; k < 82; k++) strobe(24'(k), 24'(k), 2);
      settle();
      check("mr_first", 64'(wq_addr[base]), 64'h80);
      check("mr_last", 64'(wq_addr[base + 81]), 64'hD1);
      check("mr_blk1", 64'(adc_mem_block), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
